// File: rtl/axil_regfile_pkg.sv
// Shared types and constants for the AXI4-Lite register file.
// Contents: response codes, write/read FSM state enums, response helper.
package axil_regfile_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Map a decode result onto the AXI response code.
  function automatic logic [1:0] resp_for(input logic in_range);
    return in_range ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite.sv
// AXI4-Lite bundle. Every signal carries a leading CHANNEL dimension so one
// instance can describe several parallel links; the register file uses lane 0.
// Modports: slave (responder side), master (requester side).
interface axi_lite #(
  parameter int unsigned CHANNEL    = 1,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [CHANNEL-1:0][ADDR_WIDTH-1:0] awaddr;
  logic [CHANNEL-1:0][2:0]            awprot;
  logic [CHANNEL-1:0]                 awvalid;
  logic [CHANNEL-1:0]                 awready;
  logic [CHANNEL-1:0][DATA_WIDTH-1:0] wdata;
  logic [CHANNEL-1:0][STRB_WIDTH-1:0] wstrb;
  logic [CHANNEL-1:0]                 wvalid;
  logic [CHANNEL-1:0]                 wready;
  logic [CHANNEL-1:0][1:0]            bresp;
  logic [CHANNEL-1:0]                 bvalid;
  logic [CHANNEL-1:0]                 bready;
  logic [CHANNEL-1:0][ADDR_WIDTH-1:0] araddr;
  logic [CHANNEL-1:0][2:0]            arprot;
  logic [CHANNEL-1:0]                 arvalid;
  logic [CHANNEL-1:0]                 arready;
  logic [CHANNEL-1:0][DATA_WIDTH-1:0] rdata;
  logic [CHANNEL-1:0][1:0]            rresp;
  logic [CHANNEL-1:0]                 rvalid;
  logic [CHANNEL-1:0]                 rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axil_addr_decode.sv
// Combinational register address decode.
// Ports: addr (byte address) -> index (register number), in_range (address
// lies inside the register window). Byte-offset bits below a word are ignored.
module axil_addr_decode #(
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned NUM_REGS   = 16,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [IDX_W-1:0]      index,
  output logic                  in_range
);
  localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned ADDR_HI  = ADDR_LSB + IDX_W;

  assign index    = addr[ADDR_LSB +: IDX_W];
  // Window is a power of two, so everything above the index must be zero.
  assign in_range = (addr[ADDR_WIDTH-1:ADDR_HI] == '0);

  logic unused_low_bits;
  assign unused_low_bits = ^addr[ADDR_LSB-1:0];
endmodule

// File: rtl/axil_regfile.sv
// AXI4-Lite register file: NUM_REGS read/write registers exposed to user
// logic as a flat vector plus a one-cycle write pulse per register.
// Ports: aclk, aresetn (async active-low), s_axil (axi_lite.slave, lane 0),
//        reg_out (register i at [i*DATA_WIDTH +: DATA_WIDTH]), reg_wr_pulse.
// Build option: AXIL_REGFILE_WSTRB_EN enables per-byte write strobes;
// without it the full word is always written.
module axil_regfile
  import axil_regfile_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axi_lite.slave                         s_axil,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  wr_state_t                          w_state_q;
  rd_state_t                          r_state_q;
  logic                               aw_held_q, w_held_q;
  logic                               awready_q, wready_q, bvalid_q;
  logic [1:0]                         bresp_q;
  logic [ADDR_WIDTH-1:0]              awaddr_q;
  logic [DATA_WIDTH-1:0]              wdata_q;
`ifdef AXIL_REGFILE_WSTRB_EN
  logic [STRB_W-1:0]                  wstrb_q;
`endif
  logic [NUM_REGS-1:0]                wr_pulse_q;
  logic                               arready_q, rvalid_q;
  logic [1:0]                         rresp_q;
  logic [DATA_WIDTH-1:0]              rdata_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;

  logic [IDX_W-1:0] wr_index, rd_index;
  logic             wr_in_range, rd_in_range;
  logic             aw_fire, w_fire, ar_fire, wr_commit;

  axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS))
    u_wr_decode (.addr(awaddr_q), .index(wr_index), .in_range(wr_in_range));

  axil_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS))
    u_rd_decode (.addr(s_axil.araddr[0]), .index(rd_index), .in_range(rd_in_range));

  assign aw_fire   = s_axil.awvalid[0] && awready_q;
  assign w_fire    = s_axil.wvalid[0] && wready_q;
  assign ar_fire   = s_axil.arvalid[0] && arready_q;
  assign wr_commit = (w_state_q == W_IDLE) && aw_held_q && w_held_q;

  // Write FSM: collect AW and W independently, commit once both are held.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q  <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awready_q  <= 1'b1;
      wready_q   <= 1'b1;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= '0;
`ifdef AXIL_REGFILE_WSTRB_EN
      wstrb_q    <= '0;
`endif
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      case (w_state_q)
        W_IDLE: begin
          if (wr_commit) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= resp_for(wr_in_range);
            wr_pulse_q <= wr_in_range ? (NUM_REGS'(1) << wr_index) : '0;
            w_state_q  <= W_RESP;
          end else begin
            if (aw_fire) begin
              awaddr_q  <= s_axil.awaddr[0];
              aw_held_q <= 1'b1;
              awready_q <= 1'b0;
            end
            if (w_fire) begin
              wdata_q  <= s_axil.wdata[0];
`ifdef AXIL_REGFILE_WSTRB_EN
              wstrb_q  <= s_axil.wstrb[0];
`endif
              w_held_q <= 1'b1;
              wready_q <= 1'b0;
            end
          end
        end
        W_RESP: begin
          if (s_axil.bready[0]) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
      endcase
    end
  end

  // Register update on commit; out-of-range writes leave the bank untouched.
  always_comb begin
    regs_d = regs_q;
    if (wr_commit && wr_in_range) begin
`ifdef AXIL_REGFILE_WSTRB_EN
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb_q[b]) regs_d[wr_index][b*8 +: 8] = wdata_q[b*8 +: 8];
      end
`else
      regs_d[wr_index] = wdata_q;
`endif
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) regs_q <= {NUM_REGS{RESET_VAL}};
    else          regs_q <= regs_d;
  end

  // Read FSM: sample the bank on AR handshake (pre-commit value), hold until taken.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            rdata_q   <= rd_in_range ? regs_q[rd_index] : '0;
            rresp_q   <= resp_for(rd_in_range);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axil.rready[0]) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
      endcase
    end
  end

  assign s_axil.awready[0] = awready_q;
  assign s_axil.wready[0]  = wready_q;
  assign s_axil.bvalid[0]  = bvalid_q;
  assign s_axil.bresp[0]   = bresp_q;
  assign s_axil.arready[0] = arready_q;
  assign s_axil.rvalid[0]  = rvalid_q;
  assign s_axil.rresp[0]   = rresp_q;
  assign s_axil.rdata[0]   = rdata_q;
  assign reg_out           = regs_q;
  assign reg_wr_pulse      = wr_pulse_q;

  logic unused_inputs;
`ifdef AXIL_REGFILE_WSTRB_EN
  assign unused_inputs = ^{s_axil.awprot[0], s_axil.arprot[0]};
`else
  assign unused_inputs = ^{s_axil.awprot[0], s_axil.arprot[0], s_axil.wstrb[0]};
`endif
endmodule
